// File: rtl/score_tracker.sv
// score_tracker: frame-boundary game logic producing score pulses, a BCD
// score copy (0-99, saturating) and a sticky game-over flag.
// Optional build macro: SCORE_TRACKER_GODMODE_EN (obstacle hits ignored,
// o_game_over tied low).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset/restart; first frame is partial and discarded
// PLAYING   | player clear of any gate, watching for gate entry/collision
// IN_GATE   | player overlapped a gate last frame; score on gate exit
// GAME_OVER | collision seen; held until restart

module score_tracker (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_v_sync,
   input  logic       i_de,
   input  logic       i_player_hit,
   input  logic       i_gate_hit,
   input  logic       i_obstacle_hit,
   input  logic       i_game_restart,
   output logic       o_scored,
   output logic [3:0] o_score_tens,
   output logic [3:0] o_score_units,
   output logic       o_tens_valid,
   output logic       o_game_over
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_PLAYING   = 2'd1;
   localparam logic [1:0] S_IN_GATE   = 2'd2;
   localparam logic [1:0] S_GAME_OVER = 2'd3;

   logic [1:0] r_state;
   logic       r_v_sync_d;
   logic       r_acc_gate;
   logic       r_acc_obst;
   logic       r_scored;
   logic [3:0] r_tens;
   logic [3:0] r_units;

   logic       w_boundary;
   logic       w_gate_now;
   logic       w_obst_now;
   logic       w_eval_gate;
   logic       w_eval_obst;
   logic       w_saturated;
   logic       w_score_inc;
   logic       w_do_score;
   logic [1:0] w_state_nxt;

   assign w_boundary  = i_v_sync & ~r_v_sync_d;
   assign w_gate_now  = i_de & i_player_hit & i_gate_hit;
   assign w_obst_now  = i_de & i_player_hit & i_obstacle_hit;
   // The boundary cycle's own hits belong to the frame that is closing.
   assign w_eval_gate = r_acc_gate | w_gate_now;
`ifdef SCORE_TRACKER_GODMODE_EN
   assign w_eval_obst = 1'b0;
`else
   assign w_eval_obst = r_acc_obst | w_obst_now;
`endif
   assign w_saturated = (r_tens == 4'd9) && (r_units == 4'd9);
   assign w_do_score  = w_score_inc & ~w_saturated;

   // Frame-boundary state transitions; obstacle outranks gate.
   always_comb begin
      w_state_nxt = r_state;
      w_score_inc = 1'b0;
      if (w_boundary) begin
         case (r_state)
            S_IDLE:    w_state_nxt = S_PLAYING;
            S_PLAYING: begin
               if (w_eval_obst)      w_state_nxt = S_GAME_OVER;
               else if (w_eval_gate) w_state_nxt = S_IN_GATE;
            end
            S_IN_GATE: begin
               if (w_eval_obst) begin
                  w_state_nxt = S_GAME_OVER;
               end else if (!w_eval_gate) begin
                  w_state_nxt = S_PLAYING;
                  w_score_inc = 1'b1;
               end
            end
            default:   w_state_nxt = S_GAME_OVER;
         endcase
      end
   end

   // Sync history, accumulators, FSM, score and pulse; restart wins over boundary.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v_sync_d <= 1'b0;
         r_state    <= S_IDLE;
         r_acc_gate <= 1'b0;
         r_acc_obst <= 1'b0;
         r_scored   <= 1'b0;
         r_tens     <= 4'd0;
         r_units    <= 4'd0;
      end else begin
         r_v_sync_d <= i_v_sync;
         if (i_game_restart) begin
            r_state    <= S_IDLE;
            r_acc_gate <= 1'b0;
            r_acc_obst <= 1'b0;
            r_scored   <= 1'b0;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
         end else begin
            r_state  <= w_state_nxt;
            r_scored <= w_do_score;
            if (w_boundary) begin
               r_acc_gate <= 1'b0;
               r_acc_obst <= 1'b0;
            end else begin
               r_acc_gate <= r_acc_gate | w_gate_now;
               r_acc_obst <= r_acc_obst | w_obst_now;
            end
            if (w_do_score) begin
               if (r_units == 4'd9) begin
                  r_units <= 4'd0;
                  r_tens  <= r_tens + 4'd1;
               end else begin
                  r_units <= r_units + 4'd1;
               end
            end
         end
      end
   end

`ifdef SCORE_TRACKER_GODMODE_EN
   assign o_game_over = 1'b0;
`else
   logic r_game_over;

   // Sticky collision flag mirrors entry into GAME_OVER.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)            r_game_over <= 1'b0;
      else if (i_game_restart) r_game_over <= 1'b0;
      else                     r_game_over <= (w_state_nxt == S_GAME_OVER);
   end

   assign o_game_over = r_game_over;
`endif

   assign o_scored      = r_scored;
   assign o_score_tens  = r_tens;
   assign o_score_units = r_units;
   assign o_tens_valid  = (r_tens != 4'd0);

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: frames are built from a short active
// region followed by a held v_sync; inputs change on the falling edge and
// outputs are sampled there too.
module tb_score_tracker;

`ifdef SCORE_TRACKER_GODMODE_EN
   localparam bit GOD = 1'b1;
`else
   localparam bit GOD = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_v_sync = 1'b0;
   logic       i_de = 1'b0;
   logic       i_player_hit = 1'b0;
   logic       i_gate_hit = 1'b0;
   logic       i_obstacle_hit = 1'b0;
   logic       i_game_restart = 1'b0;
   logic       o_scored;
   logic [3:0] o_score_tens;
   logic [3:0] o_score_units;
   logic       o_tens_valid;
   logic       o_game_over;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int exp_score = 0;
   logic last_p0, last_p1;
   logic [3:0] last_u0, last_t0;

   score_tracker dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_v_sync(i_v_sync), .i_de(i_de),
      .i_player_hit(i_player_hit), .i_gate_hit(i_gate_hit),
      .i_obstacle_hit(i_obstacle_hit), .i_game_restart(i_game_restart),
      .o_scored(o_scored), .o_score_tens(o_score_tens),
      .o_score_units(o_score_units), .o_tens_valid(o_tens_valid),
      .o_game_over(o_game_over)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) if (o_scored === 1'b1) pulse_cnt++;

   task automatic run_frame(input bit gate, input bit obst);
      i_v_sync = 1'b0; i_de = 1'b1; i_player_hit = 1'b1;
      i_gate_hit = gate; i_obstacle_hit = obst;
      repeat (4) @(negedge i_clk);
      i_de = 1'b0; i_player_hit = 1'b0; i_gate_hit = 1'b0; i_obstacle_hit = 1'b0;
      @(negedge i_clk);
      i_v_sync = 1'b1;
      @(negedge i_clk);
      last_p0 = o_scored; last_u0 = o_score_units; last_t0 = o_score_tens;
      @(negedge i_clk);
      last_p1 = o_scored;
      @(negedge i_clk);
      i_v_sync = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic do_pass();
      run_frame(1'b1, 1'b0);
      run_frame(1'b0, 1'b0);
   endtask

   task automatic check_score(input string name);
      checks++;
      if (o_score_tens !== 4'(exp_score / 10) || o_score_units !== 4'(exp_score % 10)) begin
         errors++;
         $display("FAIL %s score got %0d%0d expected %0d", name, o_score_tens, o_score_units, exp_score);
      end
      checks++;
      if (o_tens_valid !== (exp_score >= 10)) begin
         errors++;
         $display("FAIL %s tens_valid got %b expected %b", name, o_tens_valid, exp_score >= 10);
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (3) @(negedge i_clk);
      checks++;
      if ({o_scored, o_score_tens, o_score_units, o_tens_valid, o_game_over} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 0",
                  {o_scored, o_score_tens, o_score_units, o_tens_valid, o_game_over});
      end
      i_rst_n = 1'b1;
      @(negedge i_clk);
      begin
         int c0 = pulse_cnt;
         run_frame(1'b1, 1'b0);
         checks++;
         if ({o_scored, o_score_tens, o_score_units, o_tens_valid, o_game_over} !== 11'd0 || pulse_cnt != c0) begin
            errors++;
            $display("FAIL idle_first_frame outputs %b pulses %0d expected 0",
                     {o_scored, o_score_tens, o_score_units, o_tens_valid, o_game_over}, pulse_cnt - c0);
         end
         run_frame(1'b0, 1'b0);
         checks++;
         if (pulse_cnt != c0) begin
            errors++;
            $display("FAIL idle_discard pulses got %0d expected 0", pulse_cnt - c0);
         end
      end
      exp_score = 0;
   endtask

   task automatic test_single_pass();
      int c0 = pulse_cnt;
      repeat (3) run_frame(1'b1, 1'b0);
      checks++;
      if (pulse_cnt != c0) begin
         errors++;
         $display("FAIL in_gate_no_pulse got %0d expected 0", pulse_cnt - c0);
      end
      run_frame(1'b0, 1'b0);
      exp_score = 1;
      checks++;
      if (last_p0 !== 1'b1 || last_p1 !== 1'b0 || pulse_cnt != c0 + 1) begin
         errors++;
         $display("FAIL pulse_shape got p0=%b p1=%b n=%0d expected 1 0 1", last_p0, last_p1, pulse_cnt - c0);
      end
      checks++;
      if (last_u0 !== 4'd1 || last_t0 !== 4'd0) begin
         errors++;
         $display("FAIL digits_during_pulse got %0d%0d expected 01", last_t0, last_u0);
      end
      check_score("single_pass");
   endtask

   task automatic test_carry();
      repeat (8) do_pass();
      exp_score = 9;
      check_score("units_9");
      do_pass();
      exp_score = 10;
      checks++;
      if (last_p0 !== 1'b1 || last_t0 !== 4'd1 || last_u0 !== 4'd0) begin
         errors++;
         $display("FAIL carry_pulse got p=%b %0d%0d expected 1 10", last_p0, last_t0, last_u0);
      end
      check_score("carry_10");
      repeat (27) do_pass();
      exp_score = 37;
      check_score("score_37");
   endtask

   task automatic test_collision();
      int c0 = pulse_cnt;
      run_frame(1'b1, 1'b0);
      run_frame(1'b1, 1'b1);
      checks++;
      if (o_game_over !== !GOD || pulse_cnt != c0) begin
         errors++;
         $display("FAIL collision got go=%b pulses %0d expected go=%b pulses 0", o_game_over, pulse_cnt - c0, !GOD);
      end
      repeat (2) do_pass();
      exp_score = GOD ? 39 : 37;
      checks++;
      if (pulse_cnt != c0 + (GOD ? 2 : 0) || o_game_over !== !GOD) begin
         errors++;
         $display("FAIL after_collision pulses %0d go=%b expected %0d go=%b",
                  pulse_cnt - c0, o_game_over, GOD ? 2 : 0, !GOD);
      end
      check_score("after_collision");
   endtask

   task automatic test_restart();
      int c0;
      i_v_sync = 1'b1; i_game_restart = 1'b1;
      @(negedge i_clk);
      i_game_restart = 1'b0;
      exp_score = 0;
      checks++;
      if (o_game_over !== 1'b0 || o_scored !== 1'b0) begin
         errors++;
         $display("FAIL restart_flags got go=%b sc=%b expected 0 0", o_game_over, o_scored);
      end
      check_score("restart");
      repeat (2) @(negedge i_clk);
      i_v_sync = 1'b0;
      @(negedge i_clk);
      c0 = pulse_cnt;
      do_pass();
      checks++;
      if (pulse_cnt != c0) begin
         errors++;
         $display("FAIL restart_idle_discard pulses got %0d expected 0", pulse_cnt - c0);
      end
      do_pass();
      exp_score = 1;
      checks++;
      if (pulse_cnt != c0 + 1) begin
         errors++;
         $display("FAIL restart_then_play pulses got %0d expected 1", pulse_cnt - c0);
      end
      check_score("restart_then_play");
   endtask

   task automatic test_async_reset();
      int c0;
      run_frame(1'b1, 1'b0);
      i_v_sync = 1'b0;
      repeat (5) @(negedge i_clk);
      i_v_sync = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_scored !== 1'b1 || o_score_units !== 4'd2) begin
         errors++;
         $display("FAIL pre_reset_pulse got sc=%b u=%0d expected 1 2", o_scored, o_score_units);
      end
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_scored, o_score_tens, o_score_units, o_tens_valid, o_game_over} !== 11'd0) begin
         errors++;
         $display("FAIL async_reset got %b expected 0",
                  {o_scored, o_score_tens, o_score_units, o_tens_valid, o_game_over});
      end
      @(negedge i_clk);
      i_v_sync = 1'b0; i_rst_n = 1'b1;
      @(negedge i_clk);
      exp_score = 0;
      c0 = pulse_cnt;
      do_pass();
      checks++;
      if (pulse_cnt != c0) begin
         errors++;
         $display("FAIL post_reset_idle pulses got %0d expected 0", pulse_cnt - c0);
      end
   endtask

   task automatic test_saturation();
      int c0 = pulse_cnt;
      repeat (99) do_pass();
      exp_score = 99;
      checks++;
      if (pulse_cnt != c0 + 99) begin
         errors++;
         $display("FAIL reach_99 pulses got %0d expected 99", pulse_cnt - c0);
      end
      check_score("reach_99");
      c0 = pulse_cnt;
      do_pass();
      checks++;
      if (pulse_cnt != c0 || last_p0 !== 1'b0) begin
         errors++;
         $display("FAIL saturate pulses got %0d expected 0", pulse_cnt - c0);
      end
      check_score("saturate");
   endtask

   task automatic test_boundary_hit();
      i_v_sync = 1'b0;
      repeat (4) @(negedge i_clk);
      i_v_sync = 1'b1; i_de = 1'b1; i_player_hit = 1'b1; i_obstacle_hit = 1'b1;
      @(negedge i_clk);
      i_de = 1'b0; i_player_hit = 1'b0; i_obstacle_hit = 1'b0;
      checks++;
      if (o_game_over !== !GOD) begin
         errors++;
         $display("FAIL boundary_hit got go=%b expected %b", o_game_over, !GOD);
      end
      repeat (2) @(negedge i_clk);
      i_v_sync = 1'b0;
      @(negedge i_clk);
      run_frame(1'b0, 1'b0);
      checks++;
      if (o_game_over !== !GOD) begin
         errors++;
         $display("FAIL game_over_sticky got %b expected %b", o_game_over, !GOD);
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_carry();
      test_collision();
      test_restart();
      test_async_reset();
      test_saturation();
      test_boundary_hit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
